seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Parametrised multiplexed 7-segment display scanner for the board LED display path. It drives `DIGITS` common-select digits from a packed hex value in time-multiplexed fashion. Each digit slot starts with a blanking tick to prevent ghosting, followed by a programmable on-time for brightness control. Per-digit decimal points, per-digit enable masking and optional leading-zero blanking are supported. All inputs are captured once per frame, so a displayed frame never mixes old and new values.

## Interface
- `DIGITS`, 4: number of digits; must be ≥1.
- `DIV`, 1: clock cycles per scan tick; must be ≥1.
- `SLOT`, 8: ticks per digit slot; must be ≥2.
- `BW`, `$clog2(SLOT)`: derived width of `brightness`.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `value` in 4*DIGITS: hex nibbles; nibble i = `value[4i+3:4i]`, shown on digit i. Digit DIGITS-1 is leftmost.
- `dp` in DIGITS: decimal point per digit.
- `enable_mask` in DIGITS: 1 = digit may light.
- `lzb` in 1: leading-zero blanking enable.
- `brightness` in BW: on-ticks per slot, 0..SLOT-1. Values above SLOT-1 are treated as SLOT-1.
- `digitcode` out 8: segments, active-high. Bit 7..1 = a,b,c,d,e,f,g; bit 0 = dp.
- `selectors` out DIGITS: one-hot active-high digit select; bit i = digit i.
- `frame_start` out 1: one-cycle pulse when a new frame's inputs are captured.

## Operation
- **State counters:**
  - Prescaler `p`, 0..DIV-1.
  - Tick index `t`, 0..SLOT-1.
  - Scan index `k`, 0..DIGITS-1.
- **Counter advance:**
  - `p` increments every cycle. At DIV-1 it wraps to 0 and `t` advances.
  - `t` wraps SLOT-1→0 and advances `k`.
  - `k` wraps DIGITS-1→0.
- **Scan order:** scan index k addresses digit d = DIGITS-1-k, so the leftmost digit is scanned first.
- **Shadow capture:** in the cycle where (k,t,p)=(0,0,0), the shadow registers capture `value`, `dp`, `enable_mask`, `lzb` and `brightness`. All display decisions use shadow copies only.
- **Nibble encoding (a..g,dp):**
  - 0=11111100, 1=01100000, 2=11011010, 3=11110010
  - 4=01100110, 5=10110110, 6=10111110, 7=11100000
  - 8=11111110, 9=11110110, A=11101110, b=00111110
  - c=00011010, d=01111010, E=10011110, F=10001110
  - dp bit OR'd into bit 0.
- **Digit d is lit in tick t iff all of the following hold:**
  - 1 ≤ t ≤ brightness_shadow;
  - enable_mask_shadow[d] = 1;
  - d is not LZB-blanked.
- **When lit:** `digitcode` = encode(nibble d) | dp, and `selectors` = one-hot bit d.
- **Otherwise:** both outputs are 0. Tick 0 is therefore always dark.
- **LZB-blanked digit:** lzb_shadow=1, d≠0, and for every j≥d: nibble j = 0 and dp[j] = 0. Digit 0 is never LZB-blanked.
- **Masked digits:** they still consume their full slot time, so the frame period stays constant.

## Timing
- Frame period = DIGITS·SLOT·DIV cycles. Lit time per digit per frame = brightness·DIV cycles.
- **Output registering:** `digitcode`, `selectors` and `frame_start` are registered. Each reflects the (k,t,p) state and shadow registers of the previous cycle, so latency is 1 cycle.
- **`frame_start`:** high for exactly the one cycle following each shadow capture.
- **Reset values:**
  - p, t, k and all shadow registers = 0.
  - `digitcode`=0, `selectors`=0, `frame_start`=0.
- **Exit from reset:** the first edge with `reset` low performs the shadow capture. `frame_start`=1 in the cycle after that edge.
- **Reset mid-frame:** outputs go to 0 on the next edge. The scan restarts from digit DIGITS-1, tick 0 after release. No partial-frame output.
- **Input changes mid-frame:** ignored until the next capture.
- **Input change coinciding with capture:** the new value is taken, since capture samples the live input that cycle.
- **Selectors:** never more than one bit high; zero in every tick-0 cycle.

## Test plan
Bench uses DIGITS=4, DIV=1, SLOT=8 unless noted.

1. **Basic scan.** `value`=16'h12AF, `brightness`=7, mask=4'hF, `lzb`=0.
   - After `frame_start`: 1 dark cycle, then 7 cycles of `selectors`=1000 / `digitcode`=01100000.
   - Then 1 dark cycle and 7 cycles of 0100 / 11011010.
   - Then 0010 / 11101110, then 0001 / 10001110.
   - `frame_start` period = 32 cycles.
2. **Leading-zero blanking.** `lzb`=1.
   - `value`=16'h0040: digits 3 and 2 dark, 0010/01100110, 0001/11111100.
   - `value`=0: only 0001/11111100.
   - `value`=0, `dp`=4'b0100: digit 2 shows 0010-equivalent select 0100 / 11111101, digit 3 dark.
3. **Brightness.**
   - `brightness`=0: outputs 0 for a whole frame.
   - `brightness`=3: per slot, tick 0 dark, ticks 1–3 lit, ticks 4–7 dark.
   - `brightness`=7: ticks 1–7 lit.
4. **Frame-coherent update.** Change `value` 16'h1111→16'h2222 at cycle 10 of a frame. The remaining digits still show 1. The first 2 appears after the next `frame_start`.
5. **Reset handling.** Assert `reset` during digit-1 lit ticks.
   - Next cycle: `digitcode`=`selectors`=`frame_start`=0.
   - After release: `frame_start` 1 cycle after the first low-reset edge, and digit 3 scanned first.
6. **Parameter variant.** DIGITS=6, DIV=3, SLOT=4, `brightness`=2, mask=6'b101101.
   - Frame period = 72 cycles.
   - Each lit digit is on for 6 cycles.
   - Digits 4 and 1 stay dark while their slots are still consumed.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scanner with blanking tick, brightness, dp, masking and LZB
module seg7_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1,
    parameter int SLOT   = 8,
    parameter int BW     = $clog2(SLOT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     enable_mask,
    input  logic                  lzb,
    input  logic [BW-1:0]         brightness,
    output logic [7:0]            digitcode,
    output logic [DIGITS-1:0]     selectors,
    output logic                  frame_start
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]          p_q, p_d;
    logic [BW-1:0]          t_q, t_d;
    logic [KW-1:0]          k_q, k_d;
    logic [4*DIGITS-1:0]    value_sh_q, value_sh_d;
    logic [DIGITS-1:0]      dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]      mask_sh_q, mask_sh_d;
    logic                   lzb_sh_q, lzb_sh_d;
    logic [BW-1:0]          bri_sh_q, bri_sh_d;
    logic [7:0]             digitcode_q, digitcode_d;
    logic [DIGITS-1:0]      selectors_q, selectors_d;
    logic                   frame_start_q, frame_start_d;

    logic                   capture;
    logic [BW-1:0]          bri_eff;
    logic [DIGITS-1:0]      blank;

    function automatic logic [7:0] seg7_encode(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'b11111100;
            4'h1:    code = 8'b01100000;
            4'h2:    code = 8'b11011010;
            4'h3:    code = 8'b11110010;
            4'h4:    code = 8'b01100110;
            4'h5:    code = 8'b10110110;
            4'h6:    code = 8'b10111110;
            4'h7:    code = 8'b11100000;
            4'h8:    code = 8'b11111110;
            4'h9:    code = 8'b11110110;
            4'hA:    code = 8'b11101110;
            4'hB:    code = 8'b00111110;
            4'hC:    code = 8'b00011010;
            4'hD:    code = 8'b01111010;
            4'hE:    code = 8'b10011110;
            default: code = 8'b10001110;
        endcase
        return code;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            p_q           <= '0;
            t_q           <= '0;
            k_q           <= '0;
            value_sh_q    <= '0;
            dp_sh_q       <= '0;
            mask_sh_q     <= '0;
            lzb_sh_q      <= 1'b0;
            bri_sh_q      <= '0;
            digitcode_q   <= '0;
            selectors_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            p_q           <= p_d;
            t_q           <= t_d;
            k_q           <= k_d;
            value_sh_q    <= value_sh_d;
            dp_sh_q       <= dp_sh_d;
            mask_sh_q     <= mask_sh_d;
            lzb_sh_q      <= lzb_sh_d;
            bri_sh_q      <= bri_sh_d;
            digitcode_q   <= digitcode_d;
            selectors_q   <= selectors_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        p_d = p_q;
        t_d = t_q;
        k_d = k_q;
        if (p_q == PW'(DIV - 1)) begin
            p_d = '0;
            if (t_q == BW'(SLOT - 1)) begin
                t_d = '0;
                k_d = (k_q == KW'(DIGITS - 1)) ? '0 : k_q + 1'b1;
            end else begin
                t_d = t_q + 1'b1;
            end
        end else begin
            p_d = p_q + 1'b1;
        end
    end

    // Shadows load only at frame origin so a frame never mixes old and new inputs.
    assign capture = (p_q == '0) && (t_q == '0) && (k_q == '0);

    always_comb begin
        value_sh_d    = capture ? value       : value_sh_q;
        dp_sh_d       = capture ? dp          : dp_sh_q;
        mask_sh_d     = capture ? enable_mask : mask_sh_q;
        lzb_sh_d      = capture ? lzb         : lzb_sh_q;
        bri_sh_d      = capture ? brightness  : bri_sh_q;
        frame_start_d = capture;
    end

    if ((1 << BW) > SLOT) begin : g_clamp
        assign bri_eff = (bri_sh_q > BW'(SLOT - 1)) ? BW'(SLOT - 1) : bri_sh_q;
    end else begin : g_noclamp
        assign bri_eff = bri_sh_q;
    end

    // A digit is blanked while every digit from it leftwards is a plain zero without dp.
    always_comb begin : lzb_chain
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (value_sh_q[4*i +: 4] == 4'h0) && !dp_sh_q[i];
            if (i != 0) begin
                blank[i] = lzb_sh_q && zero_run;
            end
        end
    end

    always_comb begin : out_sel
        logic [3:0]        cur_nib;
        logic              cur_dp;
        logic              cur_en;
        logic              cur_blank;
        logic [DIGITS-1:0] sel_oh;
        logic              lit;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        sel_oh    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (k_q == KW'(DIGITS - 1 - i)) begin
                cur_nib   = value_sh_q[4*i +: 4];
                cur_dp    = dp_sh_q[i];
                cur_en    = mask_sh_q[i];
                cur_blank = blank[i];
                sel_oh[i] = 1'b1;
            end
        end
        lit         = (t_q != '0) && (t_q <= bri_eff) && cur_en && !cur_blank;
        digitcode_d = lit ? (seg7_encode(cur_nib) | {7'b0, cur_dp}) : 8'h00;
        selectors_d = lit ? sel_oh : '0;
    end

    assign digitcode   = digitcode_q;
    assign selectors   = selectors_q;
    assign frame_start = frame_start_q;

endmodule
